// File: rtl/branch_hazard_stall.sv
// ID-stage hazard/stall controller: stalls on load-use dependencies forwarding cannot cover,
// holds multi-cycle branch stalls with a small down-counter, and flushes IF/ID on taken branches.
module branch_hazard_stall #(
    parameter int BR_LOAD_STALL = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             branch,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             mem_readexe,
    input  logic             r_writeexe,
    input  logic [4:0]       wr_addrexe,
    input  logic             mem_readmem,
    input  logic             r_writemem,
    input  logic [4:0]       wr_addrmem,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, HOLD} state_e;

    localparam logic [1:0]       BrExeStall = 2'(BR_LOAD_STALL);
    localparam logic [1:0]       BrMemStall = 2'(BR_LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dep_exe, dep_mem;
    logic [1:0]       need_n;
    logic             stall;

    assign dep_exe = id_valid & r_writeexe & (wr_addrexe != 5'd0) &
                     ((use_rs & (rs == wr_addrexe)) | (use_rt & (rt == wr_addrexe)));
    assign dep_mem = id_valid & r_writemem & (wr_addrmem != 5'd0) &
                     ((use_rs & (rs == wr_addrmem)) | (use_rt & (rt == wr_addrmem)));

    always_comb begin
        need_n = 2'd0;
        if (branch && dep_exe && mem_readexe) begin
            need_n = BrExeStall;
        end else if (branch && dep_mem && mem_readmem) begin
            need_n = BrMemStall;
        end else if (!branch && dep_exe && mem_readexe) begin
            need_n = 2'd1;
        end
    end

    // In RUN the stall is Mealy on the hazard inputs; HOLD ignores them until rem runs out.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                if (need_n != 2'd0) begin
                    stall = 1'b1;
                    if (need_n > 2'd1) begin
                        state_d = HOLD;
                        rem_d   = need_n - 2'd1;
                    end
                end
            end
            HOLD: begin
                stall = 1'b1;
                rem_d = rem_q - 2'd1;
                if (rem_q == 2'd1) begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            end
            default: begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_active && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating with rst_n keeps the Mealy path quiet while reset is held, without waiting for an edge.
    assign stall_active = stall & rst_n;
    assign pc_write     = ~stall_active;
    assign ifid_write   = ~stall_active;
    assign idex_bubble  = stall_active;
    assign ifid_flush   = branch_taken & id_valid & ~stall_active & rst_n;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_branch_hazard_stall.sv
// Bench for branch_hazard_stall: directed scenarios plus random stimulus checked against a
// cycle-level model; a second instance uses BR_LOAD_STALL=3, CNT_W=4.
module tb_branch_hazard_stall;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, branch, use_rs, use_rt;
    logic [4:0] rs, rt;
    logic mem_readexe, r_writeexe, mem_readmem, r_writemem;
    logic [4:0] wr_addrexe, wr_addrmem;
    logic branch_taken;

    logic pcA, ifidA, bubA, flushA, stallA;
    logic [15:0] cntA;
    logic pcB, ifidB, bubB, flushB, stallB;
    logic [3:0] cntB;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    branch_hazard_stall uA (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .branch(branch),
        .use_rs(use_rs), .use_rt(use_rt), .rs(rs), .rt(rt),
        .mem_readexe(mem_readexe), .r_writeexe(r_writeexe), .wr_addrexe(wr_addrexe),
        .mem_readmem(mem_readmem), .r_writemem(r_writemem), .wr_addrmem(wr_addrmem),
        .branch_taken(branch_taken), .pc_write(pcA), .ifid_write(ifidA),
        .idex_bubble(bubA), .ifid_flush(flushA), .stall_active(stallA), .stall_cnt(cntA)
    );

    branch_hazard_stall #(.BR_LOAD_STALL(3), .CNT_W(4)) uB (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .branch(branch),
        .use_rs(use_rs), .use_rt(use_rt), .rs(rs), .rt(rt),
        .mem_readexe(mem_readexe), .r_writeexe(r_writeexe), .wr_addrexe(wr_addrexe),
        .mem_readmem(mem_readmem), .r_writemem(r_writemem), .wr_addrmem(wr_addrmem),
        .branch_taken(branch_taken), .pc_write(pcB), .ifid_write(ifidB),
        .idex_bubble(bubB), .ifid_flush(flushB), .stall_active(stallB), .stall_cnt(cntB)
    );

    // Reference model: stall length from the dependency rules, then "cycles still owed".
    logic depE, depM;
    int nA, nB, mHoldA, mHoldB, mCntA, mCntB;
    logic expStallA, expStallB;

    assign depE = id_valid && r_writeexe && (wr_addrexe != 5'd0) &&
                  ((use_rs && rs == wr_addrexe) || (use_rt && rt == wr_addrexe));
    assign depM = id_valid && r_writemem && (wr_addrmem != 5'd0) &&
                  ((use_rs && rs == wr_addrmem) || (use_rt && rt == wr_addrmem));

    function automatic int needN(input int brl, input logic br, input logic dE,
                                 input logic dM, input logic ldE, input logic ldM);
        if (br && dE && ldE) return brl;
        if (br && dM && ldM) return brl - 1;
        if (!br && dE && ldE) return 1;
        return 0;
    endfunction

    always_comb begin
        nA = needN(2, branch, depE, depM, mem_readexe, mem_readmem);
        nB = needN(3, branch, depE, depM, mem_readexe, mem_readmem);
        expStallA = rst_n && (mHoldA > 0 || nA > 0);
        expStallB = rst_n && (mHoldB > 0 || nB > 0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHoldA <= 0; mHoldB <= 0; mCntA <= 0; mCntB <= 0;
        end else begin
            if (expStallA) mCntA <= (mCntA == 65535) ? mCntA : mCntA + 1;
            if (expStallB) mCntB <= (mCntB == 15) ? mCntB : mCntB + 1;
            if (mHoldA > 0) mHoldA <= mHoldA - 1;
            else if (nA > 1) mHoldA <= nA - 1;
            if (mHoldB > 0) mHoldB <= mHoldB - 1;
            else if (nB > 1) mHoldB <= nB - 1;
        end
    end

    task automatic setIdle();
        id_valid = 0; branch = 0; use_rs = 0; use_rt = 0; rs = 0; rt = 0;
        mem_readexe = 0; r_writeexe = 0; wr_addrexe = 0;
        mem_readmem = 0; r_writemem = 0; wr_addrmem = 0; branch_taken = 0;
    endtask

    task automatic setExeLoad(input logic br, input logic [4:0] r);
        id_valid = 1; branch = br; use_rs = 1; rs = r;
        mem_readexe = 1; r_writeexe = 1; wr_addrexe = r;
    endtask

    task automatic test_reset();
        setExeLoad(1, 5);
        branch_taken = 1;
        #2;
        total++; if (stallA !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", stallA); end
        total++; if (pcA !== 1'b1 || ifidA !== 1'b1) begin bad++; $display("[TB] FAIL reset_write got=%b%b want=11", pcA, ifidA); end
        total++; if (bubA !== 1'b0 || flushA !== 1'b0) begin bad++; $display("[TB] FAIL reset_bub_flush got=%b%b want=00", bubA, flushA); end
        total++; if (cntA !== 16'd0 || cntB !== 4'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d want=0/0", cntA, cntB); end
        @(negedge clk);
        setIdle();
        rst_n = 1;
    endtask

    task automatic test_branch_load_exe();
        bit expA[4] = '{1, 1, 0, 0};
        bit expB[4] = '{1, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) setExeLoad(1, 5);
            else if (k == 2) setIdle();
            #2;
            total++; if (stallA !== expA[k]) begin bad++; $display("[TB] FAIL brexe_stallA k=%0d got=%b want=%b", k, stallA, expA[k]); end
            total++; if (pcA !== !expA[k] || bubA !== expA[k]) begin bad++; $display("[TB] FAIL brexe_pc_bub k=%0d got=%b%b want=%b%b", k, pcA, bubA, !expA[k], expA[k]); end
            total++; if (stallB !== expB[k]) begin bad++; $display("[TB] FAIL brexe_stallB k=%0d got=%b want=%b", k, stallB, expB[k]); end
        end
        @(negedge clk); #2;
        total++; if (cntA !== 16'd2 || cntB !== 4'd3) begin bad++; $display("[TB] FAIL brexe_cnt got=%0d/%0d want=2/3", cntA, cntB); end
    endtask

    task automatic test_branch_load_mem();
        bit expA[3] = '{1, 0, 0};
        bit expB[3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                id_valid = 1; branch = 1; use_rt = 1; rt = 7;
                mem_readmem = 1; r_writemem = 1; wr_addrmem = 7;
            end else if (k == 1) setIdle();
            #2;
            total++; if (stallA !== expA[k]) begin bad++; $display("[TB] FAIL brmem_stallA k=%0d got=%b want=%b", k, stallA, expA[k]); end
            total++; if (stallB !== expB[k]) begin bad++; $display("[TB] FAIL brmem_stallB k=%0d got=%b want=%b", k, stallB, expB[k]); end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            setIdle();
            id_valid = 1; branch = 1; use_rt = 1; rt = 7;
            r_writeexe = 1; wr_addrexe = 7;
            #2;
            total++; if (stallA !== 1'b0 || stallB !== 1'b0) begin bad++; $display("[TB] FAIL br_alu_nostall k=%0d got=%b%b want=00", k, stallA, stallB); end
        end
        @(negedge clk); setIdle(); #2;
        total++; if (cntA !== 16'd3 || cntB !== 4'd5) begin bad++; $display("[TB] FAIL brmem_cnt got=%0d/%0d want=3/5", cntA, cntB); end
    endtask

    task automatic test_alu_load();
        bit expS[3] = '{1, 0, 0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setIdle();
            if (k == 0) setExeLoad(0, 3);
            else if (k == 1) setExeLoad(0, 0);
            else begin setExeLoad(0, 3); id_valid = 0; end
            #2;
            total++; if (stallA !== expS[k] || stallB !== expS[k]) begin bad++; $display("[TB] FAIL alu_load k=%0d got=%b%b want=%b%b", k, stallA, stallB, expS[k], expS[k]); end
        end
        @(negedge clk); setIdle(); #2;
        total++; if (cntA !== 16'd4 || cntB !== 4'd6) begin bad++; $display("[TB] FAIL alu_cnt got=%0d/%0d want=4/6", cntA, cntB); end
    endtask

    task automatic test_flush();
        bit stA[6] = '{0, 1, 1, 0, 0, 0};
        bit flA[6] = '{1, 0, 0, 1, 1, 0};
        bit stB[6] = '{0, 1, 1, 1, 0, 0};
        bit flB[6] = '{1, 0, 0, 0, 1, 0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            setIdle();
            if (k == 1) setExeLoad(1, 5);
            if (k < 5) begin id_valid = 1; branch = 1; branch_taken = 1; end
            #2;
            total++; if (stallA !== stA[k] || pcA !== !stA[k]) begin bad++; $display("[TB] FAIL flush_stallA k=%0d got=%b%b want=%b%b", k, stallA, pcA, stA[k], !stA[k]); end
            total++; if (flushA !== flA[k]) begin bad++; $display("[TB] FAIL flush_A k=%0d got=%b want=%b", k, flushA, flA[k]); end
            total++; if (stallB !== stB[k] || flushB !== flB[k]) begin bad++; $display("[TB] FAIL flush_B k=%0d got=%b%b want=%b%b", k, stallB, flushB, stB[k], flB[k]); end
        end
        @(negedge clk); #2;
        total++; if (cntA !== 16'd6 || cntB !== 4'd9) begin bad++; $display("[TB] FAIL flush_cnt got=%0d/%0d want=6/9", cntA, cntB); end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        setExeLoad(1, 5);
        branch_taken = 1;
        @(negedge clk); #2;
        total++; if (stallA !== 1'b1) begin bad++; $display("[TB] FAIL midhold_pre got=%b want=1", stallA); end
        #1 rst_n = 0;
        #1;
        total++; if (stallA !== 1'b0 || pcA !== 1'b1 || ifidA !== 1'b1 || bubA !== 1'b0 || flushA !== 1'b0) begin
            bad++; $display("[TB] FAIL midhold_async got=%b%b%b%b%b want=01100", stallA, pcA, ifidA, bubA, flushA);
        end
        total++; if (stallB !== 1'b0 || cntA !== 16'd0 || cntB !== 4'd0) begin bad++; $display("[TB] FAIL midhold_cnt got=%b/%0d/%0d want=0/0/0", stallB, cntA, cntB); end
        @(negedge clk);
        setIdle();
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) @(negedge clk);
            #2;
            total++; if (stallA !== 1'b0 || stallB !== 1'b0 || cntA !== 16'd0) begin bad++; $display("[TB] FAIL midhold_after k=%0d got=%b%b/%0d want=00/0", k, stallA, stallB, cntA); end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            setExeLoad(0, 9);
            #2;
            total++; if (stallB !== 1'b1) begin bad++; $display("[TB] FAIL sat_stall k=%0d got=%b want=1", k, stallB); end
        end
        @(negedge clk); setIdle(); #2;
        total++; if (cntB !== 4'd15) begin bad++; $display("[TB] FAIL sat_cntB got=%0d want=15", cntB); end
        total++; if (cntA !== 16'd21) begin bad++; $display("[TB] FAIL sat_cntA got=%0d want=21", cntA); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            id_valid     = ($urandom_range(3, 0) != 0);
            branch       = 1'($urandom_range(1, 0));
            use_rs       = 1'($urandom_range(1, 0));
            use_rt       = 1'($urandom_range(1, 0));
            rs           = 5'($urandom_range(3, 0));
            rt           = 5'($urandom_range(3, 0));
            mem_readexe  = 1'($urandom_range(1, 0));
            r_writeexe   = 1'($urandom_range(1, 0));
            wr_addrexe   = 5'($urandom_range(3, 0));
            mem_readmem  = 1'($urandom_range(1, 0));
            r_writemem   = 1'($urandom_range(1, 0));
            wr_addrmem   = 5'($urandom_range(3, 0));
            branch_taken = 1'($urandom_range(1, 0));
            #2;
            total++; if (stallA !== expStallA || pcA !== !expStallA || bubA !== expStallA) begin
                bad++; $display("[TB] FAIL rand_A k=%0d got=%b%b%b want=%b%b%b", k, stallA, pcA, bubA, expStallA, !expStallA, expStallA);
            end
            total++; if (flushA !== (branch_taken && id_valid && !expStallA)) begin bad++; $display("[TB] FAIL rand_flushA k=%0d got=%b", k, flushA); end
            total++; if (cntA !== 16'(mCntA)) begin bad++; $display("[TB] FAIL rand_cntA k=%0d got=%0d want=%0d", k, cntA, mCntA); end
            total++; if (stallB !== expStallB || flushB !== (branch_taken && id_valid && !expStallB)) begin
                bad++; $display("[TB] FAIL rand_B k=%0d got=%b%b want_stall=%b", k, stallB, flushB, expStallB);
            end
            total++; if (cntB !== 4'(mCntB)) begin bad++; $display("[TB] FAIL rand_cntB k=%0d got=%0d want=%0d", k, cntB, mCntB); end
        end
    endtask

    initial begin
        rst_n = 1;
        setIdle();
        #1 rst_n = 0;
        test_reset();
        test_branch_load_exe();
        test_branch_load_mem();
        test_alu_load();
        test_flush();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
